// File: rtl/csa_bist_pkg.sv
// Shared definitions for the carry-skip adder BIST engine: FSM encoding,
// LFSR polynomial, directed operand vectors and the check-stage payload.
package csa_bist_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Galois mask for x^32 + x^22 + x^2 + x + 1, right-shifting form
  localparam logic [31:0] LFSR_MASK = 32'h80200003;

  localparam int unsigned NUM_DIRECTED = 4;

  // Directed vectors 0..3 at full 16-bit width; truncated to WIDTH at use
  localparam logic [15:0] DIR_A0 = 16'h0000;
  localparam logic [15:0] DIR_B0 = 16'h0000;
  localparam logic        DIR_C0 = 1'b0;
  localparam logic [15:0] DIR_A1 = 16'hFFFF;
  localparam logic [15:0] DIR_B1 = 16'h0001;
  localparam logic        DIR_C1 = 1'b0;
  localparam logic [15:0] DIR_A2 = 16'hFFFF;
  localparam logic [15:0] DIR_B2 = 16'hFFFF;
  localparam logic        DIR_C2 = 1'b1;
  localparam logic [15:0] DIR_A3 = 16'hAAAA;
  localparam logic [15:0] DIR_B3 = 16'h5555;
  localparam logic        DIR_C3 = 1'b1;

  // Check-register payload; operand fields hold WIDTH bits zero-extended to 16
  typedef struct packed {
    logic [15:0] idx;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
  } cap_t;

  // An all-zero seed would lock the LFSR; substitute 1
  function automatic logic [31:0] fix_seed(input logic [31:0] seed);
    return (seed == 32'd0) ? 32'h1 : seed;
  endfunction

endpackage

// File: rtl/csa_bist_lfsr.sv
// 32-bit right-shifting Galois LFSR with synchronous seed load and advance.
// Ports: clk, rst_n (async active-low), load (reload seed, wins over adv),
//        adv (step once), value (current register contents).
module csa_bist_lfsr
  import csa_bist_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE12B7D
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        adv,
  output logic [31:0] value
);

  localparam logic [31:0] SEED_EFF = fix_seed(SEED);

  logic [31:0] lfsr_q;
  logic [31:0] lfsr_d;

  // Next value: reload, one Galois step, or hold
  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = SEED_EFF;
    end else if (adv) begin
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_MASK : 32'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED_EFF;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value = lfsr_q;

endmodule

// File: rtl/csa_bist_engine.sv
// Self-test driver/checker for an external WIDTH-bit adder. Drives one operand
// vector per cycle (4 directed, rest LFSR), captures the adder response at the
// end of each drive cycle, compares it with a behavioural a+b+cin one cycle
// later and reports pass/fail, a saturating error count and the first failure.
// Ports: clk, rst_n, start | dut_a/dut_b/dut_cin out, dut_sum/dut_cout in |
//        busy, done, pass, err_count, first_fail_idx/a/b.
// Optional feature macro CSA_BIST_INJECT_EN adds inject_idx/inject_en, which
// flip bit 0 of the captured sum for one vector to exercise the checker.
module csa_bist_engine
  import csa_bist_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned NUM_VECTORS = 1024,
  parameter logic [31:0] SEED        = 32'hACE12B7D,
  parameter int unsigned ERR_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef CSA_BIST_INJECT_EN
  input  logic [15:0]      inject_idx,
  input  logic             inject_en,
`endif
  output logic [WIDTH-1:0] dut_a,
  output logic [WIDTH-1:0] dut_b,
  output logic             dut_cin,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [15:0]      first_fail_idx,
  output logic [WIDTH-1:0] first_fail_a,
  output logic [WIDTH-1:0] first_fail_b
);

  localparam logic [15:0]      LAST_IDX = 16'(NUM_VECTORS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic             drain_q, drain_d;
  logic [15:0]      idx_q, idx_d;
  logic [WIDTH-1:0] dut_a_q, dut_a_d;
  logic [WIDTH-1:0] dut_b_q, dut_b_d;
  logic             dut_cin_q, dut_cin_d;
  logic             cap_vld_q, cap_vld_d;
  cap_t             cap_q, cap_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [15:0]      ffi_q, ffi_d;
  logic [WIDTH-1:0] ffa_q, ffa_d;
  logic [WIDTH-1:0] ffb_q, ffb_d;

  logic             lfsr_load;
  logic             lfsr_adv;
  logic [31:0]      lfsr_val;

  logic [15:0]      sel_idx;
  logic [WIDTH-1:0] vec_a;
  logic [WIDTH-1:0] vec_b;
  logic             vec_cin;
  logic [WIDTH:0]   sum_ref;
  logic [WIDTH:0]   sum_got;
  logic             mismatch;
  logic             start_ok;

  csa_bist_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .adv   (lfsr_adv),
    .value (lfsr_val)
  );

  // Operand vector for the index about to be driven (0 when a run starts)
  always_comb begin
    sel_idx = (state_q == ST_RUN) ? (idx_q + 16'd1) : 16'd0;
    vec_a   = WIDTH'(DIR_A0);
    vec_b   = WIDTH'(DIR_B0);
    vec_cin = DIR_C0;
    case (sel_idx)
      16'd0: begin vec_a = WIDTH'(DIR_A0); vec_b = WIDTH'(DIR_B0); vec_cin = DIR_C0; end
      16'd1: begin vec_a = WIDTH'(DIR_A1); vec_b = WIDTH'(DIR_B1); vec_cin = DIR_C1; end
      16'd2: begin vec_a = WIDTH'(DIR_A2); vec_b = WIDTH'(DIR_B2); vec_cin = DIR_C2; end
      16'd3: begin vec_a = WIDTH'(DIR_A3); vec_b = WIDTH'(DIR_B3); vec_cin = DIR_C3; end
      default: begin
        vec_a   = lfsr_val[WIDTH-1:0];
        vec_b   = lfsr_val[16 +: WIDTH];
        vec_cin = lfsr_val[0] ^ lfsr_val[31];
      end
    endcase
  end

  // Reference and observed results for the captured vector
  always_comb begin
    sum_ref  = (WIDTH+1)'(cap_q.a[WIDTH-1:0]) + (WIDTH+1)'(cap_q.b[WIDTH-1:0])
             + (WIDTH+1)'(cap_q.cin);
    sum_got  = {cap_q.cout, cap_q.sum[WIDTH-1:0]};
    mismatch = cap_vld_q && (sum_got != sum_ref);
  end

  assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // Next-state, drive, capture and scoreboard update
  always_comb begin
    state_d   = state_q;
    drain_d   = drain_q;
    idx_d     = idx_q;
    dut_a_d   = dut_a_q;
    dut_b_d   = dut_b_q;
    dut_cin_d = dut_cin_q;
    cap_vld_d = 1'b0;
    cap_d     = cap_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    err_d     = err_q;
    ffi_d     = ffi_q;
    ffa_d     = ffa_q;
    ffb_d     = ffb_q;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;

    // Error count freezes at all-ones; first failure latched while count is zero
    if (mismatch) begin
      if (err_q != ERR_MAX) begin
        err_d = err_q + ERR_W'(1);
      end
      if (err_q == '0) begin
        ffi_d = cap_q.idx;
        ffa_d = cap_q.a[WIDTH-1:0];
        ffb_d = cap_q.b[WIDTH-1:0];
      end
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          state_d   = ST_RUN;
          idx_d     = 16'd0;
          dut_a_d   = vec_a;
          dut_b_d   = vec_b;
          dut_cin_d = vec_cin;
          lfsr_load = 1'b1;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          err_d     = '0;
          ffi_d     = 16'hFFFF;
          ffa_d     = '0;
          ffb_d     = '0;
        end
      end
      ST_RUN: begin
        // Sample the adder response to the vector currently on dut_*
        cap_vld_d = 1'b1;
        cap_d.idx = idx_q;
        cap_d.a   = 16'(dut_a_q);
        cap_d.b   = 16'(dut_b_q);
        cap_d.cin = dut_cin_q;
        cap_d.sum = 16'(dut_sum);
        cap_d.cout = dut_cout;
`ifdef CSA_BIST_INJECT_EN
        if (inject_en && (idx_q == inject_idx)) begin
          cap_d.sum[0] = ~cap_d.sum[0];
        end
`endif
        if (idx_q == LAST_IDX) begin
          state_d = ST_DRAIN;
          drain_d = 1'b0;
        end else begin
          idx_d     = sel_idx;
          dut_a_d   = vec_a;
          dut_b_d   = vec_b;
          dut_cin_d = vec_cin;
          lfsr_adv  = (sel_idx >= 16'(NUM_DIRECTED));
        end
      end
      ST_DRAIN: begin
        // First cycle finishes the last compare, second publishes the result
        if (drain_q) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_q == '0);
        end else begin
          drain_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      drain_q   <= 1'b0;
      idx_q     <= 16'd0;
      dut_a_q   <= '0;
      dut_b_q   <= '0;
      dut_cin_q <= 1'b0;
      cap_vld_q <= 1'b0;
      cap_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= '0;
      ffi_q     <= 16'hFFFF;
      ffa_q     <= '0;
      ffb_q     <= '0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      idx_q     <= idx_d;
      dut_a_q   <= dut_a_d;
      dut_b_q   <= dut_b_d;
      dut_cin_q <= dut_cin_d;
      cap_vld_q <= cap_vld_d;
      cap_q     <= cap_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
      ffi_q     <= ffi_d;
      ffa_q     <= ffa_d;
      ffb_q     <= ffb_d;
    end
  end

  assign dut_a          = dut_a_q;
  assign dut_b          = dut_b_q;
  assign dut_cin        = dut_cin_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_fail_idx = ffi_q;
  assign first_fail_a   = ffa_q;
  assign first_fail_b   = ffb_q;

endmodule

// File: tb/tb_csa_bist_engine.sv
// Bench for csa_bist_engine: behavioural adder with selectable faults, a
// reference vector generator, table-driven runs and reset/saturation sequences.
module tb_csa_bist_engine;

  localparam logic [31:0] SEED = 32'hACE12B7D;
  localparam int          NV   = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        start2 = 1'b0;
  logic [15:0] inject_idx = 16'd0;
  logic        inject_en = 1'b0;
  int          fault_mode = 0;

  logic [15:0] dut_a, dut_b, dut_sum, first_fail_idx, first_fail_a, first_fail_b;
  logic        dut_cin, dut_cout, busy, done, pass;
  logic [15:0] err_count;

  logic [15:0] dut_a2, dut_b2, ffi2, ffa2, ffb2;
  logic        dut_cin2, busy2, done2, pass2;
  logic [1:0]  err2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Adder under test: correct, or with sum[3] stuck at 0
  always_comb begin
    {dut_cout, dut_sum} = 17'(dut_a) + 17'(dut_b) + 17'(dut_cin);
    if (fault_mode == 1) dut_sum[3] = 1'b0;
  end

  csa_bist_engine #(.WIDTH(16), .NUM_VECTORS(NV), .SEED(SEED), .ERR_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef CSA_BIST_INJECT_EN
    .inject_idx(inject_idx), .inject_en(inject_en),
`endif
    .dut_a(dut_a), .dut_b(dut_b), .dut_cin(dut_cin),
    .dut_sum(dut_sum), .dut_cout(dut_cout),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_fail_idx(first_fail_idx), .first_fail_a(first_fail_a), .first_fail_b(first_fail_b)
  );

  // Second engine sees an adder whose outputs are stuck at zero
  csa_bist_engine #(.WIDTH(16), .NUM_VECTORS(NV), .SEED(SEED), .ERR_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
`ifdef CSA_BIST_INJECT_EN
    .inject_idx(16'd0), .inject_en(1'b0),
`endif
    .dut_a(dut_a2), .dut_b(dut_b2), .dut_cin(dut_cin2),
    .dut_sum(16'd0), .dut_cout(1'b0),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .first_fail_idx(ffi2), .first_fail_a(ffa2), .first_fail_b(ffb2)
  );

  typedef struct {
    string       name;
    int          mode;
    int          restart_at;
    int          inj;
    logic        exp_pass;
    logic [15:0] exp_ffi;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    logic [31:0] n;
    n = {1'b0, l[31:1]};
    if (l[0]) n = n ^ 32'h80200003;
    return n;
  endfunction

  // Reference vector i as {a,b,cin}; consumes one LFSR step for i>=4
  task automatic model_vec(input int i, inout logic [31:0] l, output logic [32:0] v);
    case (i)
      0: v = {16'h0000, 16'h0000, 1'b0};
      1: v = {16'hFFFF, 16'h0001, 1'b0};
      2: v = {16'hFFFF, 16'hFFFF, 1'b1};
      3: v = {16'hAAAA, 16'h5555, 1'b1};
      default: begin
        v = {l[15:0], l[31:16], l[0] ^ l[31]};
        l = lfsr_step(l);
      end
    endcase
  endtask

  task automatic model_run(input int mode, input int inj, output int errs,
                           output logic [15:0] fa, output logic [15:0] fb);
    logic [31:0] l;
    logic [32:0] v;
    logic [16:0] good, got;
    l = SEED; errs = 0; fa = 16'd0; fb = 16'd0;
    for (int i = 0; i < NV; i++) begin
      model_vec(i, l, v);
      good = 17'(v[32:17]) + 17'(v[16:1]) + 17'(v[0]);
      got = good;
      if (mode == 1) got[3] = 1'b0;
      if (i == inj) got[0] = ~got[0];
      if (got != good) begin
        if (errs == 0) begin fa = v[32:17]; fb = v[16:1]; end
        errs++;
      end
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_ops"}, {dut_a, dut_b, dut_cin}, 33'd0);
    chk({nm, "_flags"}, {busy, done, pass}, 3'b000);
    chk({nm, "_err"}, err_count, 16'd0);
    chk({nm, "_ffi"}, first_fail_idx, 16'hFFFF);
    chk({nm, "_ffab"}, {first_fail_a, first_fail_b}, 32'd0);
  endtask

  task automatic do_run(input vec_t t);
    logic [31:0] l;
    logic [32:0] v;
    int          errs;
    logic [15:0] fa, fb;
    fault_mode = t.mode;
    inject_en  = (t.inj >= 0);
    inject_idx = (t.inj >= 0) ? 16'(t.inj) : 16'd0;
    model_run(t.mode, t.inj, errs, fa, fb);
    l = SEED;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int k = 0; k < NV + 2; k++) begin
      if (k < NV) begin
        model_vec(k, l, v);
        chk($sformatf("%s_vec%0d", t.name, k), {dut_a, dut_b, dut_cin}, v);
      end
      chk($sformatf("%s_busy%0d", t.name, k), {busy, done}, 2'b10);
      if (k == t.restart_at) start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
    end
    chk({t.name, "_end"}, {busy, done}, 2'b01);
    chk({t.name, "_pass"}, pass, t.exp_pass);
    chk({t.name, "_err"}, err_count, 16'(errs));
    chk({t.name, "_ffi"}, first_fail_idx, t.exp_ffi);
    chk({t.name, "_ffab"}, {first_fail_a, first_fail_b}, {fa, fb});
    inject_en = 1'b0;
  endtask

  vec_t tab[4];
  int   n_tab;

  initial begin
    tab[0] = '{"correct", 0, -1, -1, 1'b1, 16'hFFFF};
    tab[1] = '{"stuck3",  1, -1, -1, 1'b0, 16'h0002};
    tab[2] = '{"restart", 0,  3, -1, 1'b1, 16'hFFFF};
    tab[3] = '{"inject",  0, -1,  5, 1'b0, 16'h0005};
`ifdef CSA_BIST_INJECT_EN
    n_tab = 4;
`else
    n_tab = 3;
`endif

    repeat (2) @(negedge clk);
    chk_reset("rst_hold");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset("rst_idle");

    for (int i = 0; i < n_tab; i++) do_run(tab[i]);

    // Stuck-at-0 first fail operands are the directed all-ones pair
    fault_mode = 1;
    do_run(tab[1]);
    chk("stuck3_ffa_hand", {first_fail_a, first_fail_b}, {16'hFFFF, 16'hFFFF});
    fault_mode = 0;

    // Abort mid-run: reset with vector 5 on the bus
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_reset("abort");
    @(negedge clk); rst_n = 1'b1;
    do_run(tab[0]);

    // Saturating 2-bit counter against an all-zero adder
    @(negedge clk); start2 = 1'b1;
    @(posedge clk); #1; start2 = 1'b0;
    repeat (NV + 1) @(posedge clk);
    #1;
    chk("sat_not_done", done2, 1'b0);
    @(posedge clk); #1;
    chk("sat_flags", {busy2, done2, pass2}, 3'b010);
    chk("sat_err", err2, 2'd3);
    chk("sat_ffi", ffi2, 16'd1);
    chk("sat_ffab", {ffa2, ffb2}, {16'hFFFF, 16'h0001});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
